// File: rtl/ip_frame_shifter_pkg.sv
// Shared constants and state encoding for the QSIC indicator panel shifter.
// Frame geometry: four 36-bit lamp rows in one 144-bit chain.
package ip_frame_shifter_pkg;

   localparam int IP_ROWS       = 4;
   localparam int IP_ROW_BITS   = 36;
   localparam int IP_FRAME_BITS = IP_ROWS * IP_ROW_BITS;
   localparam int IP_CNT_W      = 8;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LATCH = 2'd2
   } ip_state_e;

endpackage

// File: rtl/ip_frame_shifter_tick_div.sv
// ip_tick_div: free-running 0..CLK_DIV-1 counter with synchronous clear.
// tick marks the last system cycle of each phase.
module ip_tick_div #(
   parameter int CLK_DIV = 100
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/ip_frame_shifter.sv
// QSIC panel serializer: LOAD snapshot, 144-bit SHIFT, 2-phase LATCH.
// Optional IP_LAMP_TEST_EN adds lamp_test (all-ones snapshot at LOAD).
module ip_frame_shifter
   import ip_frame_shifter_pkg::*;
#(
   parameter int CLK_DIV = 100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [35:0] lamps0,
   input  logic [35:0] lamps1,
   input  logic [35:0] lamps2,
   input  logic [35:0] lamps3,
`ifdef IP_LAMP_TEST_EN
   input  logic        lamp_test,
`endif
   output logic        frame_start,
   output logic        ip_clk,
   output logic        ip_latch,
   output logic        ip_out
);

   localparam logic [IP_CNT_W-1:0] LAST_BIT = IP_CNT_W'(IP_FRAME_BITS - 1);

   ip_state_e                state;
   logic                     hi;
   logic [IP_CNT_W-1:0]      bit_cnt;
   logic [IP_FRAME_BITS-1:0] shreg;
   logic [IP_FRAME_BITS-1:0] snap;
   logic                     tick;
   logic                     div_clr;
   logic                     sclk;
   logic                     data;
   logic                     latch;

   assign div_clr = (state == ST_LOAD);

   ip_tick_div #(
      .CLK_DIV (CLK_DIV)
   ) u_div (
      .clk   (clk),
      .reset (reset),
      .clear (div_clr),
      .tick  (tick)
   );

`ifdef IP_LAMP_TEST_EN
   assign snap = lamp_test ? '1 : {lamps0, lamps1, lamps2, lamps3};
`else
   assign snap = {lamps0, lamps1, lamps2, lamps3};
`endif

   always_comb begin
      sclk  = (state == ST_SHIFT) && hi;
      data  = (state == ST_SHIFT) && shreg[IP_FRAME_BITS-1];
      latch = (state == ST_LATCH);
   end

   // Held low during reset so an aborted frame never looks like a start.
   assign frame_start = (state == ST_LOAD) && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_LOAD;
         hi       <= 1'b0;
         bit_cnt  <= '0;
         shreg    <= '0;
         ip_clk   <= 1'b1;
         ip_latch <= 1'b1;
         ip_out   <= 1'b1;
      end else begin
         ip_clk   <= ~sclk;
         ip_latch <= ~latch;
         ip_out   <= ~data;
         unique case (state)
            ST_LOAD: begin
               shreg   <= snap;
               hi      <= 1'b0;
               bit_cnt <= '0;
               state   <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (tick) begin
                  if (!hi) begin
                     hi <= 1'b1;
                  end else begin
                     hi      <= 1'b0;
                     shreg   <= {shreg[IP_FRAME_BITS-2:0], 1'b0};
                     bit_cnt <= bit_cnt + 1'b1;
                     if (bit_cnt == LAST_BIT) begin
                        state <= ST_LATCH;
                     end
                  end
               end
            end
            ST_LATCH: begin
               if (tick) begin
                  if (!hi) begin
                     hi <= 1'b1;
                  end else begin
                     hi    <= 1'b0;
                     state <= ST_LOAD;
                  end
               end
            end
            default: begin
               state <= ST_LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ip_frame_shifter.sv
// Bench for ip_frame_shifter at CLK_DIV = 4 (frame = 1161 cycles).
// Frame-position model checked every cycle plus directed literal checks.
module tb_ip_frame_shifter;

   localparam int D  = 4;
   localparam int FL = 1 + 290 * D;
   localparam logic [35:0] PAT = 36'o525252525252;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [35:0] lamps0, lamps1, lamps2, lamps3;
`ifdef IP_LAMP_TEST_EN
   logic        lamp_test = 1'b0;
`endif
   logic        frame_start, ip_clk, ip_latch, ip_out;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   ip_frame_shifter #(.CLK_DIV(D)) dut (
      .clk         (clk),
      .reset       (reset),
      .lamps0      (lamps0),
      .lamps1      (lamps1),
      .lamps2      (lamps2),
      .lamps3      (lamps3),
`ifdef IP_LAMP_TEST_EN
      .lamp_test   (lamp_test),
`endif
      .frame_start (frame_start),
      .ip_clk      (ip_clk),
      .ip_latch    (ip_latch),
      .ip_out      (ip_out)
   );

   task automatic chk(input string nm, input logic [143:0] act,
                      input logic [143:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at t=%0t: got %h want %h", nm, $time, act, exp);
      end
   endtask

   // ---------------- model: frame position + snapshot ----------------
   int           t = 0;
   logic         rs = 1'b0;
   logic         live = 1'b0;
   logic [143:0] snap = '0;

   function automatic logic [143:0] lamp_bits();
`ifdef IP_LAMP_TEST_EN
      if (lamp_test) return '1;
`endif
      return {lamps0, lamps1, lamps2, lamps3};
   endfunction

   // Expected {ip_clk, ip_latch, ip_out} at frame cycle tt.
   function automatic logic [2:0] exp_pins(input int tt, input logic r,
                                           input logic [143:0] s);
      int u, k, p;
      if (r) return 3'b111;
      if (tt == 0) return 3'b101;
      u = tt - 1;
      if (u == 0) return 3'b111;
      if (u <= 288 * D) begin
         k = (u - 1) / (2 * D);
         p = (u - 1) % (2 * D);
         return {(p < D), 1'b1, ~s[143-k]};
      end
      return 3'b101;
   endfunction

   always @(posedge clk) begin
      live <= live | reset;
      rs   <= reset;
      if (!reset && t == 0) snap <= lamp_bits();
      t <= reset ? 0 : ((t == FL - 1) ? 0 : t + 1);
   end

   always @(negedge clk) begin
      if (live) begin
         chk("frame_start", 144'(frame_start), 144'(!reset && t == 0));
         chk("pins", 144'({ip_clk, ip_latch, ip_out}), 144'(exp_pins(t, rs, snap)));
      end
   end

   // ---------------- serial capture monitor ----------------
   logic         pclk = 1'b1;
   logic [143:0] cap = '0;
   int           ncap = 0;
   int           nlat = 0;

   always @(negedge clk) begin
      if (live) begin
         if (pclk && !ip_clk) begin
            cap  <= {cap[142:0], ~ip_out};
            ncap <= ncap + 1;
         end
         if (!ip_latch) nlat <= nlat + 1;
         pclk <= ip_clk;
      end
   end

   // ---------------- directed stimulus ----------------
   int cc = 0;
   int m_cap, m_lat;
   int f3, f4;
   logic [143:0] one_hot;

   task automatic goto_cyc(input int c);
      repeat (c - cc) @(posedge clk);
      #1;
      cc = c;
   endtask

   initial begin
      lamps0 = 36'o400000000000;
      lamps1 = '0;
      lamps2 = '0;
      lamps3 = '0;
      one_hot = '0;
      one_hot[143] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      cc = 0;
      @(negedge clk);
      chk("c0_fs", 144'(frame_start), 144'(1));
      chk("c0_pins", 144'({ip_clk, ip_latch, ip_out}), 144'(3'b111));
      goto_cyc(1);
      m_cap = ncap;
      m_lat = nlat;
      @(negedge clk);
      chk("c1_out", 144'(ip_out), 144'(1));
      goto_cyc(2);
      @(negedge clk);
      chk("c2_out", 144'(ip_out), 144'(0));
      chk("c2_clk", 144'(ip_clk), 144'(1));
      goto_cyc(6);
      @(negedge clk);
      chk("c6_clk", 144'(ip_clk), 144'(0));
      goto_cyc(9);
      @(negedge clk);
      chk("c9_out", 144'(ip_out), 144'(0));
      goto_cyc(10);
      @(negedge clk);
      chk("c10_out", 144'(ip_out), 144'(1));
      chk("c10_clk", 144'(ip_clk), 144'(1));
      goto_cyc(500);
      lamps0 = '1;
      lamps1 = '1;
      lamps2 = '1;
      lamps3 = '1;
      goto_cyc(1153);
      @(negedge clk);
      chk("c1153_latch", 144'(ip_latch), 144'(1));
      goto_cyc(1154);
      @(negedge clk);
      chk("c1154_latch", 144'(ip_latch), 144'(0));
      goto_cyc(1161);
      @(negedge clk);
      chk("c1161_fs", 144'(frame_start), 144'(1));
      chk("c1161_latch", 144'(ip_latch), 144'(0));
      goto_cyc(1162);
      chk("f1_nbits", 144'(ncap - m_cap), 144'(144));
      chk("f1_bits", cap, one_hot);
      chk("f1_latch_len", 144'(nlat - m_lat), 144'(8));
      @(negedge clk);
      chk("c1162_latch", 144'(ip_latch), 144'(1));
      goto_cyc(1163);
      @(negedge clk);
      chk("f2_bit0_out", 144'(ip_out), 144'(0));
      goto_cyc(1300);
      lamps0 = '0;
      lamps1 = '0;
      lamps2 = '0;
      lamps3 = '0;
      goto_cyc(1161 + 500);
      @(negedge clk);
      chk("f2_mid_out", 144'(ip_out), 144'(0));
      goto_cyc(1761);
      m_lat = nlat;
      reset = 1'b1;
      goto_cyc(1762);
      @(negedge clk);
      chk("rst_pins", 144'({ip_clk, ip_latch, ip_out}), 144'(3'b111));
      chk("rst_fs", 144'(frame_start), 144'(0));
      goto_cyc(1764);
      lamps0 = PAT;
      lamps1 = PAT;
      lamps2 = PAT;
      lamps3 = PAT;
      reset = 1'b0;
      f3 = 1764;
      @(negedge clk);
      chk("rel_fs", 144'(frame_start), 144'(1));
      goto_cyc(f3 + 1);
      chk("abort_no_latch", 144'(nlat - m_lat), 144'(0));
      m_cap = ncap;
      m_lat = nlat;
      f4 = f3 + FL;
      goto_cyc(f4 - 5);
      lamps0 = '0;
      lamps1 = '0;
      lamps2 = '0;
      lamps3 = '0;
`ifdef IP_LAMP_TEST_EN
      lamp_test = 1'b1;
`endif
      goto_cyc(f4 + 1);
      chk("f3_nbits", 144'(ncap - m_cap), 144'(144));
      chk("f3_bits", cap, {PAT, PAT, PAT, PAT});
      chk("f3_latch_len", 144'(nlat - m_lat), 144'(8));
      m_cap = ncap;
      goto_cyc(f4 + 2);
      @(negedge clk);
`ifdef IP_LAMP_TEST_EN
      chk("f4_bit0_out", 144'(ip_out), 144'(0));
`else
      chk("f4_bit0_out", 144'(ip_out), 144'(1));
`endif
      goto_cyc(f4 + 300);
`ifdef IP_LAMP_TEST_EN
      lamp_test = 1'b0;
`endif
      goto_cyc(f4 + FL + 1);
      chk("f4_nbits", 144'(ncap - m_cap), 144'(144));
`ifdef IP_LAMP_TEST_EN
      chk("f4_bits", cap, '1);
`else
      chk("f4_bits", cap, '0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not complete, got timeout want finish");
      $fatal(1, "timeout");
   end

endmodule
